// File: rtl/lsu_mem_if.sv
// lsu_mem_if: one-at-a-time load/store initiator for the byte-addressed RAM.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of doing them.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef MASK_BYTE
`define MASK_BYTE   2'b00
`define MASK_HALF   2'b01
`define MASK_WORD   2'b10
`define MASK_DOUBLE 2'b11
`endif

module lsu_mem_if #(
   parameter int ADDR_BITS = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_store_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [`XLEN-1:0]  req_addr_i,
   input  logic [`XLEN-1:0]  req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [`XLEN-1:0]  resp_rdata_o,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic              resp_err_o,
`endif
   output logic [`XLEN-1:0]  ram_addr_o,
   output logic              ram_wen_o,
   output logic [`XLEN-1:0]  ram_wdata_o,
   output logic [1:0]        ram_wmask_o,
   input  logic [`XLEN-1:0]  ram_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t st_q, st_d;

   logic                 store_q;
   logic [1:0]           size_q;
   logic                 uns_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [`XLEN-1:0]     wdata_q;
   logic [`XLEN-1:0]     rdata_q;
   logic                 accept;
   logic                 err;

   assign accept = req_valid_i & req_ready_o;

   function automatic logic [`XLEN-1:0] extend(
      input logic [1:0]       size,
      input logic             uns,
      input logic [`XLEN-1:0] d
   );
      logic [`XLEN-1:0] r;
      r = d;
      unique case (1'b1)
         (size == `MASK_BYTE):
            r = {{(`XLEN-8){~uns & d[7]}}, d[7:0]};
         (size == `MASK_HALF):
            r = {{(`XLEN-16){~uns & d[15]}}, d[15:0]};
         (size == `MASK_WORD):
            r = {{(`XLEN-32){~uns & d[31]}}, d[31:0]};
         default:
            r = d;
      endcase
      return r;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [2:0] a
   );
      logic m;
      m = 1'b0;
      unique case (1'b1)
         (size == `MASK_HALF):   m = a[0];
         (size == `MASK_WORD):   m = |a[1:0];
         (size == `MASK_DOUBLE): m = |a[2:0];
         default:                m = 1'b0;
      endcase
      return m;
   endfunction

   // Flag lives for one transaction: set at accept, cleared leaving RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= misaligned(req_size_i, req_addr_i[2:0]);
      end else if (st_q == S_RESP && resp_ready_i) begin
         err_q <= 1'b0;
      end
   end

   assign err        = err_q;
   assign resp_err_o = err_q & resp_valid_o;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= S_IDLE;
      end else begin
         st_q <= st_d;
      end
   end

   // RAM port is only live in ACCESS, so reset kills a write at once.
   always_comb begin
      st_d         = st_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      ram_wen_o    = 1'b0;
      ram_addr_o   = '0;
      ram_wdata_o  = '0;
      ram_wmask_o  = `MASK_BYTE;
      unique case (st_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) st_d = S_ACCESS;
         end
         S_ACCESS: begin
            ram_addr_o  = {{(`XLEN-ADDR_BITS){1'b0}}, addr_q};
            ram_wdata_o = wdata_q;
            ram_wmask_o = size_q;
            ram_wen_o   = store_q & ~err;
            st_d        = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) st_d = S_IDLE;
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q <= 1'b0;
         size_q  <= `MASK_BYTE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         store_q <= req_store_i;
         size_q  <= req_size_i;
         uns_q   <= req_unsigned_i;
         addr_q  <= req_addr_i[ADDR_BITS-1:0];
         wdata_q <= req_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (st_q == S_ACCESS) begin
         if (store_q || err) begin
            rdata_q <= '0;
         end else begin
            rdata_q <= extend(size_q, uns_q, ram_rdata_i);
         end
      end
   end

   assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: scoreboard bench for lsu_mem_if with a byte RAM model.
// Set LSU_MISALIGN_TRAP_EN to exercise the misalignment trap build.

`ifndef MASK_BYTE
`define MASK_BYTE   2'b00
`define MASK_HALF   2'b01
`define MASK_WORD   2'b10
`define MASK_DOUBLE 2'b11
`endif

module tb_lsu_mem_if;

   localparam int AB = 10;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_uns = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] ram_addr;
   logic        ram_wen;
   logic [63:0] ram_wdata;
   logic [1:0]  ram_wmask;
   logic [63:0] ram_rdata;

   always #5 clk = ~clk;

   lsu_mem_if #(.ADDR_BITS(AB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_store_i    (req_store),
      .req_size_i     (req_size),
      .req_unsigned_i (req_uns),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_rdata_o   (resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
      .resp_err_o     (resp_err),
`endif
      .ram_addr_o     (ram_addr),
      .ram_wen_o      (ram_wen),
      .ram_wdata_o    (ram_wdata),
      .ram_wmask_o    (ram_wmask),
      .ram_rdata_i    (ram_rdata)
   );

`ifndef LSU_MISALIGN_TRAP_EN
   assign resp_err = 1'b0;
`endif

   // Byte RAM: write at posedge per size mask, combinational 8-byte read.
   logic [7:0] mem [0:1023];

   always @(posedge clk) begin
      if (ram_wen) begin
         for (int i = 0; i < (1 << ram_wmask); i++)
            mem[10'(ram_addr[9:0] + 10'(i))] <= ram_wdata[8*i +: 8];
      end
   end

   always_comb begin
      ram_rdata = '0;
      for (int i = 0; i < 8; i++)
         ram_rdata[8*i +: 8] = mem[10'(ram_addr[9:0] + 10'(i))];
   end

   int wen_cnt = 0;
   always @(negedge clk) if (ram_wen) wen_cnt++;

   logic [7:0] ref_mem [0:1023];

   typedef struct {
      logic        err;
      logic [63:0] rd;
   } exp_t;

   exp_t sb[$];

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] ref_read(input logic [63:0] a,
                                            input logic [1:0] sz,
                                            input logic un);
      int n;
      logic [63:0] v;
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++)
         v[8*i +: 8] = ref_mem[10'(a[9:0] + 10'(i))];
      if (!un && n < 8 && v[8*n-1])
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic mis(input logic [1:0] sz, input logic [63:0] a);
      return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) ||
             (sz == 2'd3 && a[2:0] != 0);
   endfunction

   task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int stall);
      exp_t e, g;
      int w0, n, wexp;
      e.err = TRAP && mis(sz, a);
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = st;
      req_size   = sz;
      req_uns    = un;
      req_addr   = a;
      req_wdata  = wd;
      resp_ready = (stall == 0);
      if (st) begin
         e.rd = '0;
         if (!e.err)
            for (int i = 0; i < (1 << sz); i++)
               ref_mem[10'(a[9:0] + 10'(i))] = wd[8*i +: 8];
      end else begin
         e.rd = e.err ? 64'd0 : ref_read(a, sz, un);
      end
      sb.push_back(e);
      w0   = wen_cnt;
      wexp = (st && !e.err) ? 1 : 0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("acc_wen", 64'(ram_wen), 64'(wexp));
      check("acc_addr", ram_addr, {54'd0, a[9:0]});
      check("acc_mask", 64'(ram_wmask), 64'(sz));
      check("acc_wdata", ram_wdata, wd);
      n = 0;
      while (!resp_valid && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 64'(n), 64'd1);
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
         g = e;
      end else begin
         g = sb.pop_front();
      end
      check("rdata", resp_rdata, g.rd);
      check("err", 64'(resp_err), 64'(g.err));
      check("resp_no_req", 64'(req_ready), 64'd0);
      for (int k = 0; k < stall; k++) begin
         req_valid = 1'b1;
         req_store = 1'b1;
         req_addr  = 64'h40;
         @(posedge clk);
         #1;
         check("stall_valid", 64'(resp_valid), 64'd1);
         check("stall_rdata", resp_rdata, g.rd);
         check("stall_ready", 64'(req_ready), 64'd0);
         check("stall_addr", ram_addr, 64'd0);
      end
      check("wen_cnt", 64'(wen_cnt - w0), 64'(wexp));
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("done_valid", 64'(resp_valid), 64'd0);
      check("done_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_valid", 64'(resp_valid), 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_err", 64'(resp_err), 64'd0);
      check("rst_wen", 64'(ram_wen), 64'd0);
      check("rst_addr", ram_addr, 64'd0);
      check("rst_wdata", ram_wdata, 64'd0);
      check("rst_mask", 64'(ram_wmask), 64'(`MASK_BYTE));
      rst_n = 1'b1;

      // fill a scratch region so every later load reads written bytes
      for (int i = 0; i < 16; i++)
         issue(1, 2'd3, 0, 64'h80 + 64'(8*i), {$urandom, $urandom}, 0);

      issue(1, 2'd3, 0, 64'h10, 64'h8877665544332211, 0);
      issue(0, 2'd3, 0, 64'h10, 64'h0, 0);
      issue(1, 2'd0, 0, 64'h10, 64'h123456789ABCDE80, 0);
      issue(0, 2'd0, 0, 64'h10, 64'h0, 0);
      issue(0, 2'd0, 1, 64'h10, 64'h0, 0);
      issue(1, 2'd2, 0, 64'h14, 64'hFFFFFFFF80000000, 0);
      issue(0, 2'd2, 0, 64'h14, 64'h0, 0);
      issue(0, 2'd1, 1, 64'h14, 64'h0, 0);
      issue(0, 2'd1, 0, 64'h16, 64'h0, 0);
      issue(0, 2'd2, 1, 64'h14, 64'h0, 0);
      issue(1, 2'd3, 0, 64'h20, 64'hA5A5A5A5_5A5A5A5A, 5);
      issue(0, 2'd3, 0, 64'h10, 64'h0, 5);

      // reset during the ACCESS cycle of a store
      issue(1, 2'd3, 0, 64'h30, 64'h0123456789ABCDEF, 0);
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b1;
      req_size  = 2'd3;
      req_addr  = 64'h30;
      req_wdata = 64'hDEADBEEFDEADBEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rstacc_wen_on", 64'(ram_wen), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rstacc_wen_off", 64'(ram_wen), 64'd0);
      check("rstacc_valid", 64'(resp_valid), 64'd0);
      check("rstacc_ready", 64'(req_ready), 64'd1);
      check("rstacc_addr", ram_addr, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(0, 2'd3, 0, 64'h30, 64'h0, 0);

      // misaligned word store, then view the surrounding bytes
      issue(1, 2'd2, 0, 64'h12, 64'h00000000CAFEBABE, 0);
      issue(0, 2'd3, 0, 64'h10, 64'h0, 0);
      issue(0, 2'd1, 0, 64'h13, 64'h0, 0);

      // wrap past the top of the RAM and ignored upper address bits
      issue(1, 2'd3, 0, 64'h3FC, 64'h1122334455667788, 0);
      issue(0, 2'd3, 0, 64'h3FC, 64'h0, 0);
      issue(0, 2'd3, 0, 64'hFFFF000000000010, 64'h0, 0);

      for (int i = 0; i < 24; i++)
         issue(1'($urandom), 2'($urandom), 1'($urandom),
               64'h80 + 64'($urandom_range(0, 'h77)),
               {$urandom, $urandom}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store initiator for the byte-addressed data RAM. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the RAM's address, write-enable, write-data and size-mask port for exactly one cycle. For loads it captures the RAM's combinational read data, then size-extends and sign- or zero-extends it. It returns a registered response over a second valid/ready handshake. Sits between the EX/MEM pipeline logic and `ram`.

## Interface
Parameters:
- `ADDR_BITS`, 10, number of low address bits forwarded to the RAM; upper bits of `ram_addr_o` are driven 0.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request.
- `req_store_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  access size, encoded as `MASK_BYTE`/`MASK_HALF`/`MASK_WORD`/`MASK_DOUBLE` from defines.v.
- `req_unsigned_i`  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- `req_addr_i`  in  `XLEN`  byte address.
- `req_wdata_i`  in  `XLEN`  store data, LSB-aligned.
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  consumer accepts the response.
- `resp_rdata_o`  out  `XLEN`  extended load data; 0 for stores.
- `resp_err_o`  out  1  misaligned access flag. Only exists under `LSU_MISALIGN_TRAP_EN`.
- `ram_addr_o`  out  `XLEN`  RAM address.
- `ram_wen_o`  out  1  RAM write enable.
- `ram_wdata_o`  out  `XLEN`  RAM write data.
- `ram_wmask_o`  out  2  RAM size mask.
- `ram_rdata_i`  in  `XLEN`  RAM combinational read data: bytes addr+7..addr.

## Operation
The block has three states.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`&&`req_ready_o`, register store, size, unsigned, `addr[ADDR_BITS-1:0]` and wdata, then go to ACCESS.
- **ACCESS** (exactly one cycle)
  - `ram_addr_o`/`ram_wmask_o`/`ram_wdata_o` are driven from the registered request.
  - `ram_wen_o` = registered store flag.
  - Loads: the result register latches `ram_rdata_i` with extension applied:
    - BYTE: bits [7:0], extended from bit 7.
    - HALF: bits [15:0], extended from bit 15.
    - WORD: bits [31:0], extended from bit 31.
    - DOUBLE: all 64 bits, no extension.
  - Stores: the result register latches 0.
  - Always go to RESP next.
- **RESP**
  - `resp_valid_o`=1, with `resp_rdata_o` held stable.
  - On `resp_ready_i`, go to IDLE.
  - `req_ready_o`=0; the block does no request/response overlap.
- Outside ACCESS: `ram_wen_o`=0, `ram_addr_o`=0, `ram_wdata_o`=0, `ram_wmask_o`=`MASK_BYTE`.
- Store data is passed unmasked; the RAM writes only the bytes selected by the mask.
- No address range checking is done. A wrap past the top of the RAM follows the RAM's own `ADDR_BITS` truncation.

## Timing
- Reset values: state IDLE; `req_ready_o`=1; `resp_valid_o`=0; `resp_rdata_o`=0; `resp_err_o`=0; all `ram_*` outputs as in the idle values above.
- Request accepted at edge N:
  - ACCESS is active during cycle N..N+1, and a store writes the RAM at edge N+1.
  - `resp_valid_o` is high from edge N+1.
  - Minimum request-to-response latency is 2 edges.
  - Maximum throughput is one transaction per 3 cycles when `resp_ready_i` is held high.
- `resp_ready_i` held low: the block stays in RESP indefinitely with outputs stable, and `req_valid_i` is ignored.
- `resp_ready_i` asserted in a cycle where `resp_valid_o`=0 has no effect.
- `rst_n` low in any state:
  - Immediate return to IDLE and reset values.
  - An in-flight transaction is dropped.
  - `ram_wen_o` drops asynchronously, so no partial write occurs after the reset edge.
- Request fields are don't-care when `req_valid_i`=0; only the values captured at the accept edge matter.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - In IDLE, an accepted request with addr not aligned to its size (HALF addr[0]≠0; WORD addr[1:0]≠0; DOUBLE addr[2:0]≠0) sets an error flag.
  - In ACCESS with the flag set: `ram_wen_o`=0 and the result latches 0.
  - In RESP: `resp_err_o`=1 while `resp_valid_o`.
  - The flag clears on return to IDLE.
- Not defined: the `resp_err_o` port is absent, and misaligned accesses are performed byte-exact, since the RAM is byte-addressed.

## Test plan
- Reset, then store DOUBLE addr 0x10 data 0x8877665544332211, then load DOUBLE 0x10 -> `resp_rdata_o`=0x8877665544332211; `ram_wen_o` high for exactly one cycle.
- Load BYTE signed addr 0x10 after writing 0x80 there -> 0xFFFFFFFFFFFFFF80; same load unsigned -> 0x0000000000000080.
- Load WORD signed addr 0x14 containing 0x80000000 -> 0xFFFFFFFF80000000; load HALF unsigned at the same address -> 0x0000000000000000.
- Hold `resp_ready_i`=0 for 5 cycles with `req_valid_i`=1 -> `resp_valid_o` and data stable, `req_ready_o`=0, no second RAM access.
- Assert `rst_n`=0 during ACCESS of a store -> `ram_wen_o` drops immediately, target bytes unchanged, state IDLE, `resp_valid_o`=0.
- With `LSU_MISALIGN_TRAP_EN`: store WORD addr 0x12 -> `resp_err_o`=1, RAM unchanged. Without the macro: same store writes bytes 0x12..0x15.
